uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter. Successor to the fixed 8N1 transmitter.

---
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side push handshake for the buffered UART transmitter.
// The producer holds word and valid; the transmitter answers with ready.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_din_i;
    logic              tx_valid_i;
    logic              tx_ready_o;

    modport master (
        output tx_din_i,
        output tx_valid_i,
        input  tx_ready_o
    );

    modport slave (
        input  tx_din_i,
        input  tx_valid_i,
        output tx_ready_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with runtime baud divisor, parity and stop bits.
// Frame settings are captured when a word leaves the FIFO.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    uart_tx_fifo_if.slave                 bus,
    input  logic [DIV_W-1:0]              baud_div_i,
    input  logic [1:0]                    parity_mode_i,
    input  logic                          stop2_i,
    output logic                          tx_o,
    output logic                          tx_active_o,
    output logic                          tx_done_tick_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              push, pop;
    logic [DATA_W-1:0] head;

    logic [2:0]        state, state_n;
    logic [DIV_W-1:0]  cnt, cnt_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic [BW-1:0]     bidx, bidx_n;
    logic              sidx, sidx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par_q, par_n;
    logic [1:0]        mode_q, mode_n;
    logic              stop2_q, stop2_n;
    logic              tx_n;
    logic              bit_end;

    assign bus.tx_ready_o = (level != FULL);
    assign push           = bus.tx_valid_i && (level != FULL);
    assign head           = mem[rd_ptr];
    assign fifo_level_o   = level;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.tx_din_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        bidx_n  = bidx;
        sidx_n  = sidx;
        shreg_n = shreg;
        par_n   = par_q;
        div_n   = div_q;
        mode_n  = mode_q;
        stop2_n = stop2_q;
        pop     = 1'b0;
        bit_end = (cnt == div_q);
        unique case (state)
            IDLE: pop = (level != '0);
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bidx_n  = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bidx == LAST_BIT) begin
                        state_n = (mode_q != 2'b00) ? PARITY : STOP;
                        sidx_n  = 1'b0;
                    end else begin
                        bidx_n = bidx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    sidx_n  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (sidx == stop2_q) begin
                        if (level != '0) pop = 1'b1;
                        else state_n = IDLE;
                    end else begin
                        sidx_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        cnt_n = (bit_end || state == IDLE) ? '0 : cnt + 1'b1;
        // Popping a word also freezes the settings for that whole frame.
        if (pop) begin
            state_n = START;
            cnt_n   = '0;
            shreg_n = head;
            div_n   = baud_div_i;
            mode_n  = parity_mode_i;
            stop2_n = stop2_i;
            unique case (parity_mode_i)
                2'b01:   par_n = ^head;
                2'b10:   par_n = ~^head;
                default: par_n = 1'b1;
            endcase
        end
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            cnt            <= '0;
            div_q          <= '0;
            bidx           <= '0;
            sidx           <= 1'b0;
            shreg          <= '0;
            par_q          <= 1'b0;
            mode_q         <= 2'b00;
            stop2_q        <= 1'b0;
            tx_o           <= 1'b1;
            tx_active_o    <= 1'b0;
            tx_done_tick_o <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            div_q          <= div_n;
            bidx           <= bidx_n;
            sidx           <= sidx_n;
            shreg          <= shreg_n;
            par_q          <= par_n;
            mode_q         <= mode_n;
            stop2_q        <= stop2_n;
            tx_o           <= tx_n;
            tx_active_o    <= (state_n != IDLE);
            // Tick lands on the clock that is the last one of the final stop bit.
            tx_done_tick_o <= (state_n == STOP) && (sidx_n == stop2_n)
                              && (cnt_n == div_n);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-clock line capture against expected frames.
// Each scenario task drives stimulus and checks its own results.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic        tx, tx_active, tx_done;
    logic [2:0]  level;
    int          total = 0;
    int          passed = 0;

    uart_tx_fifo_if #(.DATA_W(8)) bus ();

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .bus            (bus),
        .baud_div_i     (baud_div),
        .parity_mode_i  (parity_mode),
        .stop2_i        (stop2),
        .tx_o           (tx),
        .tx_active_o    (tx_active),
        .tx_done_tick_o (tx_done),
        .fifo_level_o   (level)
    );

    always #5 clk = ~clk;

    task automatic add_frame(input logic [7:0] d, input int div,
                             input logic [1:0] m, input logic s2,
                             inout logic [255:0] tw, inout logic [255:0] dw,
                             inout int n);
        logic [11:0] seq;
        int nb;
        seq = '0;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1+i] = d[i];
        nb = 9;
        if (m != 2'b00) begin
            seq[nb] = (m == 2'b01) ? ^d : (m == 2'b10) ? ~^d : 1'b1;
            nb++;
        end
        seq[nb] = 1'b1;
        nb++;
        if (s2) begin
            seq[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++)
            for (int r = 0; r <= div; r++) begin
                tw[n] = seq[b];
                n++;
            end
        dw[n-1] = 1'b1;
    endtask

    task automatic close_exp(input int n, inout logic [255:0] tw,
                             inout logic [255:0] aw);
        for (int i = 0; i < n; i++) aw[i] = 1'b1;
        tw[n] = 1'b1;
    endtask

    task automatic capture(input int n, output logic [255:0] tw,
                           output logic [255:0] dw, output logic [255:0] aw);
        tw = '0;
        dw = '0;
        aw = '0;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tw[k] = tx;
            dw[k] = tx_done;
            aw[k] = tx_active;
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        bus.tx_din_i   = d;
        bus.tx_valid_i = 1'b1;
        while (!bus.tx_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL push_timeout: ready low for %0d cycles, want < 200", n);
        end
        @(posedge clk);
        #1;
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_active || level != 3'd0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            total++;
            $display("FAIL idle_timeout: still active after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++; if (tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx); else passed++;
        total++; if (tx_active !== 1'b0) $display("FAIL rst_active: got %b want 0", tx_active); else passed++;
        total++; if (tx_done !== 1'b0) $display("FAIL rst_done: got %b want 0", tx_done); else passed++;
        total++; if (level !== 3'd0) $display("FAIL rst_level: got %0d want 0", level); else passed++;
        total++; if (bus.tx_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.tx_ready_o); else passed++;
    endtask

    task automatic test_basic();
        logic [255:0] tw, dw, aw, etw, edw, eaw;
        int n = 0;
        etw = '0; edw = '0; eaw = '0;
        baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
        add_frame(8'h51, 3, 2'b00, 1'b0, etw, edw, n);
        close_exp(n, etw, eaw);
        push_word(8'h51);
        capture(n + 1, tw, dw, aw);
        total++; if (tw !== etw) $display("FAIL basic_tx: got %h want %h", tw, etw); else passed++;
        total++; if (dw !== edw) $display("FAIL basic_done: got %h want %h", dw, edw); else passed++;
        total++; if (aw !== eaw) $display("FAIL basic_active: got %h want %h", aw, eaw); else passed++;
        wait_idle();
    endtask

    task automatic test_parity();
        logic [255:0] tw, dw, aw, etw, edw, eaw;
        logic [1:0] modes [3] = '{2'b01, 2'b10, 2'b11};
        logic       pbit  [3] = '{1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 3; t++) begin
            int n = 0;
            etw = '0; edw = '0; eaw = '0;
            baud_div = 16'd3; parity_mode = modes[t]; stop2 = 1'b0;
            add_frame(8'hA3, 3, modes[t], 1'b0, etw, edw, n);
            close_exp(n, etw, eaw);
            push_word(8'hA3);
            capture(n + 1, tw, dw, aw);
            total++; if (tw[36] !== pbit[t]) $display("FAIL parity_bit_m%0d: got %b want %b", t + 1, tw[36], pbit[t]); else passed++;
            total++; if (tw !== etw || dw !== edw) $display("FAIL parity_frame_m%0d: got %h want %h", t + 1, tw, etw); else passed++;
            wait_idle();
        end
    endtask

    task automatic test_stop2();
        logic [255:0] tw, dw, aw, etw, edw, eaw;
        int n = 0;
        etw = '0; edw = '0; eaw = '0;
        baud_div = 16'd1; parity_mode = 2'b00; stop2 = 1'b1;
        add_frame(8'h00, 1, 2'b00, 1'b1, etw, edw, n);
        close_exp(n, etw, eaw);
        push_word(8'h00);
        capture(n + 1, tw, dw, aw);
        total++; if (tw !== etw) $display("FAIL stop2_tx: got %h want %h", tw, etw); else passed++;
        total++; if (dw !== edw) $display("FAIL stop2_done: got %h want %h", dw, edw); else passed++;
        total++; if (aw !== eaw) $display("FAIL stop2_active: got %h want %h", aw, eaw); else passed++;
        stop2 = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [255:0] tw, dw, aw, etw, edw, eaw;
        logic [7:0] words [6] = '{8'h11, 8'h22, 8'hC4, 8'h0F, 8'hF0, 8'h99};
        int n = 0;
        etw = '0; edw = '0; eaw = '0;
        baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 6; i++) add_frame(words[i], 0, 2'b00, 1'b0, etw, edw, n);
        close_exp(n, etw, eaw);
        push_word(words[0]);
        fork
            begin
                for (int i = 1; i < 5; i++) push_word(words[i]);
                @(negedge clk);
                total++; if (bus.tx_ready_o !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", bus.tx_ready_o); else passed++;
                total++; if (level !== 3'd4) $display("FAIL b2b_full_level: got %0d want 4", level); else passed++;
                push_word(words[5]);
            end
            capture(n + 1, tw, dw, aw);
        join
        total++; if (tw !== etw) $display("FAIL b2b_tx: got %h want %h", tw, etw); else passed++;
        total++; if (dw !== edw) $display("FAIL b2b_done: got %h want %h", dw, edw); else passed++;
        total++; if (aw !== eaw) $display("FAIL b2b_active: got %h want %h", aw, eaw); else passed++;
        total++; if (level !== 3'd0) $display("FAIL b2b_end_level: got %0d want 0", level); else passed++;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [255:0] tw, dw, aw, etw, edw, eaw;
        int n = 0;
        int lows = 0;
        int ticks = 0;
        baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
        push_word(8'h5A);
        push_word(8'h33);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        total++; if (tx !== 1'b1) $display("FAIL mid_rst_tx: got %b want 1", tx); else passed++;
        total++; if (tx_active !== 1'b0) $display("FAIL mid_rst_active: got %b want 0", tx_active); else passed++;
        total++; if (level !== 3'd0) $display("FAIL mid_rst_level: got %0d want 0", level); else passed++;
        total++; if (bus.tx_ready_o !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", bus.tx_ready_o); else passed++;
        for (int k = 0; k < 50; k++) begin
            if (tx_done) ticks++;
            if (!tx) lows++;
            @(negedge clk);
        end
        total++; if (ticks + lows !== 0) $display("FAIL mid_rst_quiet: got %0d ticks %0d low clocks want 0", ticks, lows); else passed++;
        etw = '0; edw = '0; eaw = '0;
        add_frame(8'h3C, 3, 2'b00, 1'b0, etw, edw, n);
        close_exp(n, etw, eaw);
        push_word(8'h3C);
        capture(n + 1, tw, dw, aw);
        total++; if (tw !== etw || dw !== edw) $display("FAIL mid_rst_next: got %h want %h", tw, etw); else passed++;
        wait_idle();
    endtask

    task automatic test_cfg_change();
        logic [255:0] tw, dw, aw, etw, edw, eaw;
        int n = 0;
        etw = '0; edw = '0; eaw = '0;
        baud_div = 16'd3; parity_mode = 2'b01; stop2 = 1'b0;
        add_frame(8'h0F, 3, 2'b01, 1'b0, etw, edw, n);
        add_frame(8'h81, 1, 2'b10, 1'b1, etw, edw, n);
        close_exp(n, etw, eaw);
        push_word(8'h0F);
        fork
            begin
                push_word(8'h81);
                repeat (5) @(negedge clk);
                baud_div = 16'd1; parity_mode = 2'b10; stop2 = 1'b1;
            end
            capture(n + 1, tw, dw, aw);
        join
        total++; if (tw !== etw) $display("FAIL cfg_tx: got %h want %h", tw, etw); else passed++;
        total++; if (dw !== edw) $display("FAIL cfg_done: got %h want %h", dw, edw); else passed++;
        total++; if (aw !== eaw) $display("FAIL cfg_active: got %h want %h", aw, eaw); else passed++;
        baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
        wait_idle();
    endtask

    initial begin
        bus.tx_din_i   = '0;
        bus.tx_valid_i = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_reset_mid();
        test_cfg_change();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
